// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader: widths, timing default
// and the state encodings of the loader FSM and of the UART receiver.
package imem_uart_loader_pkg;

  localparam int unsigned ISA_WIDTH         = 32;
  localparam int unsigned IMEM_ADDR_WIDTH   = 14;
  localparam int unsigned UART_CLKS_PER_BIT = 10416;
  localparam int unsigned LEN_WIDTH         = 16;

  typedef enum logic [2:0] {
    LOADER_S_IDLE  = 3'd0,
    LOADER_S_LEN   = 3'd1,
    LOADER_S_DATA  = 3'd2,
    LOADER_S_WRITE = 3'd3,
    LOADER_S_CHK   = 3'd4,
    LOADER_S_DONE  = 3'd5,
    LOADER_S_ERR   = 3'd6
  } loader_state_t;

  typedef enum logic [2:0] {
    RX_S_IDLE  = 3'd0,
    RX_S_START = 3'd1,
    RX_S_DATA  = 3'd2,
    RX_S_STOP  = 3'd3,
    RX_S_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/imem_uart_loader_uart_rx.sv
// uart_byte_rx: 8N1 receiver with a 2-flop synchroniser and mid-bit sampling.
// rx_valid / frame_err are one-cycle pulses; rx_data holds the last byte.
module uart_byte_rx
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  rx_state_t        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_cnt, bit_cnt_d;
  logic [7:0]       shreg, shreg_d;
  logic             valid_d, ferr_d;
  logic             sync_0, rx_s;

  // Synchroniser, state and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_0    <= 1'b1;
      rx_s      <= 1'b1;
      state     <= RX_S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_0    <= uart_rx;
      rx_s      <= sync_0;
      state     <= state_d;
      cnt       <= cnt_d;
      bit_cnt   <= bit_cnt_d;
      shreg     <= shreg_d;
      rx_valid  <= valid_d;
      frame_err <= ferr_d;
    end
  end

  // Bit timing and framing: validate start at half a bit, then sample each full bit
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CNT_W'(1);
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state)
      RX_S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = RX_S_START;
      end
      RX_S_START: begin
        if (cnt == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? RX_S_IDLE : RX_S_DATA;
        end
      end
      RX_S_DATA: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d     = '0;
          shreg_d   = {rx_s, shreg[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = RX_S_STOP;
        end
      end
      RX_S_STOP: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (rx_s) begin
            valid_d = 1'b1;
            state_d = RX_S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_S_BREAK;
          end
        end
      end
      RX_S_BREAK: begin
        // A low stop bit: wait for the line to return high before hunting a start
        cnt_d = '0;
        if (rx_s) state_d = RX_S_IDLE;
      end
      default: state_d = RX_S_IDLE;
    endcase
  end

  assign rx_data = shreg;

endmodule

// File: rtl/imem_uart_loader.sv
// imem_uart_loader: receives a length-prefixed program image over UART and writes it
// word-by-word into instruction memory, holding the CPU in reset while loading.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR byte verified in CHK).
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned ADDR_WIDTH   = IMEM_ADDR_WIDTH,
  parameter int unsigned DEPTH_WORDS  = 16384
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic                  uart_rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [ISA_WIDTH-1:0]  imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  logic       rx_valid, frame_err;
  logic [7:0] rx_data;

  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock    (clock),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .frame_err(frame_err)
  );

  loader_state_t         state, state_d;
  logic [LEN_WIDTH-1:0]  len, len_d, len_full;
  logic [LEN_WIDTH-1:0]  word_cnt, word_cnt_d;
  logic [1:0]            byte_cnt, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ISA_WIDTH-1:0]  wdata_d;
  logic [7:0]            csum, csum_d;
  logic                  we_d, hold_d, busy_d, done_d, error_d;
  logic                  load_en_q, load_rise, load_fall;

  assign load_rise = load_en & ~load_en_q;
  assign load_fall = ~load_en & load_en_q;
  assign len_full  = {rx_data, len[7:0]};

  // State, datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= LOADER_S_IDLE;
      len        <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      csum       <= '0;
      load_en_q  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_d;
      len        <= len_d;
      word_cnt   <= word_cnt_d;
      byte_cnt   <= byte_cnt_d;
      csum       <= csum_d;
      load_en_q  <= load_en;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      cpu_hold   <= hold_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

  // Loader sequencing: length header, byte gathering, word writes, completion
  always_comb begin
    state_d    = state;
    len_d      = len;
    word_cnt_d = word_cnt;
    byte_cnt_d = byte_cnt;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;
    csum_d     = csum;
    we_d       = 1'b0;
    case (state)
      LOADER_S_IDLE, LOADER_S_DONE, LOADER_S_ERR: begin
        if (load_rise) begin
          state_d    = LOADER_S_LEN;
          len_d      = '0;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          addr_d     = '0;
          wdata_d    = '0;
          csum_d     = '0;
        end
      end
      LOADER_S_LEN: begin
        if (load_fall || frame_err) begin
          state_d = LOADER_S_ERR;
        end else if (rx_valid) begin
          if (byte_cnt == 2'd0) begin
            len_d[7:0] = rx_data;
            byte_cnt_d = 2'd1;
          end else begin
            len_d      = len_full;
            byte_cnt_d = 2'd0;
            if (len_full == '0)                  state_d = LOADER_S_DONE;
            else if (32'(len_full) > DEPTH_WORDS) state_d = LOADER_S_ERR;
            else                                 state_d = LOADER_S_DATA;
          end
        end
      end
      LOADER_S_DATA: begin
        if (load_fall || frame_err) begin
          state_d = LOADER_S_ERR;
        end else if (rx_valid) begin
          wdata_d    = {rx_data, imem_wdata[ISA_WIDTH-1:8]};
          csum_d     = csum ^ rx_data;
          byte_cnt_d = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            we_d    = 1'b1;
            state_d = LOADER_S_WRITE;
          end
        end
      end
      LOADER_S_WRITE: begin
        // The write strobe is out this cycle; advance the address only if more words follow
        word_cnt_d = word_cnt + LEN_WIDTH'(1);
        if (load_fall) begin
          state_d = LOADER_S_ERR;
        end else if (word_cnt + LEN_WIDTH'(1) == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = LOADER_S_CHK;
`else
          state_d = LOADER_S_DONE;
`endif
        end else begin
          addr_d  = imem_addr + ADDR_WIDTH'(1);
          state_d = LOADER_S_DATA;
        end
      end
      LOADER_S_CHK: begin
        if (load_fall || frame_err) state_d = LOADER_S_ERR;
        else if (rx_valid)          state_d = (rx_data == csum) ? LOADER_S_DONE : LOADER_S_ERR;
      end
      default: state_d = LOADER_S_IDLE;
    endcase

    busy_d  = (state_d == LOADER_S_LEN) || (state_d == LOADER_S_DATA) ||
              (state_d == LOADER_S_WRITE) || (state_d == LOADER_S_CHK);
    hold_d  = busy_d || (state_d == LOADER_S_ERR);
    done_d  = (state_d == LOADER_S_DONE);
    error_d = (state_d == LOADER_S_ERR);
  end

  // A byte can never complete during a write cycle given the UART bit time
  a_no_rx_in_write: assert property (@(posedge clock) disable iff (reset)
    !(rx_valid && (state == LOADER_S_WRITE)));

endmodule

// File: tb/tb_imem_uart_loader.sv
// Scoreboard bench for imem_uart_loader: expected writes are queued as stimulus is
// issued; a monitor pops and compares on every imem_we. Status checked per scenario.
module tb_imem_uart_loader;
  import imem_uart_loader_pkg::*;

  localparam int unsigned CPB = 16;

  logic        clock = 1'b0;
  logic        reset, load_en, uart_rx;
  logic        imem_we, cpu_hold, busy, done, error;
  logic [13:0] imem_addr;
  logic [31:0] imem_wdata;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(14), .DEPTH_WORDS(16384)) dut (
    .clock     (clock),
    .reset     (reset),
    .load_en   (load_en),
    .uart_rx   (uart_rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [13:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the head of the expected queue
  always @(negedge clock) begin
    if (!reset && imem_we) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 imem_addr, imem_wdata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(w.addr));
        check("wr_data", imem_wdata, w.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop_bit;
    tick(CPB);
    uart_rx = 1'b1;
    tick(2);
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    tick(4);
  endtask

  task automatic arm();
    load_en = 1'b0;
    tick(2);
    load_en = 1'b1;
    tick(2);
  endtask

  task automatic check_status(input string name, input logic e_done, input logic e_err,
                              input logic e_hold, input logic e_busy);
    @(negedge clock);
    check({name, "_done"},  32'(done),     32'(e_done));
    check({name, "_error"}, 32'(error),    32'(e_err));
    check({name, "_hold"},  32'(cpu_hold), 32'(e_hold));
    check({name, "_busy"},  32'(busy),     32'(e_busy));
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clock);
    check({name, "_we"},    32'(imem_we),    32'd0);
    check({name, "_addr"},  32'(imem_addr),  32'd0);
    check({name, "_wdata"}, imem_wdata,      32'd0);
    check({name, "_hold"},  32'(cpu_hold),   32'd0);
    check({name, "_busy"},  32'(busy),       32'd0);
    check({name, "_done"},  32'(done),       32'd0);
    check({name, "_error"}, 32'(error),      32'd0);
  endtask

  // Image from the first scenario (N=2), plus its XOR checksum when enabled
  task automatic send_image1(input logic [7:0] csum);
    logic [7:0] img[$];
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    img.push_back(csum);
`else
    if (csum != 8'h00) img = img;
`endif
    exp_q.push_back('{addr: 14'd0, data: 32'h0000_0013});
    exp_q.push_back('{addr: 14'd1, data: 32'h0010_0093});
    send_bytes(img);
  endtask

  initial begin
    logic [7:0] seq[$];
    reset   = 1'b1;
    load_en = 1'b0;
    uart_rx = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    tick(2);

    // Arming raises hold and busy
    arm();
    @(negedge clock);
    check("arm_hold", 32'(cpu_hold), 32'd1);
    check("arm_busy", 32'(busy),     32'd1);

    // Two-word image; XOR of data bytes 13^93^10 = 0x90
    send_image1(8'h90);
    check_status("img1", 1'b1, 1'b0, 1'b0, 1'b0);

    // Byte arriving in DONE is discarded
    seq = '{8'hAA};
    send_bytes(seq);
    check_status("done_discard", 1'b1, 1'b0, 1'b0, 1'b0);

    // Zero-length image
    arm();
    seq = '{8'h00, 8'h00};
    send_bytes(seq);
    check_status("len0", 1'b1, 1'b0, 1'b0, 1'b0);

    // Length beyond depth
    arm();
    seq = '{8'h01, 8'h40};
    send_bytes(seq);
    check_status("too_long", 1'b0, 1'b1, 1'b1, 1'b0);

    // Frame error on the third data byte: no write for word 0
    arm();
    seq = '{8'h01, 8'h00, 8'h11, 8'h22};
    send_bytes(seq);
    send_byte(8'h33, 1'b0);
    tick(4);
    check_status("frame_err", 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset after five of eight data bytes, then a clean reload from addr 0
    arm();
    exp_q.push_back('{addr: 14'd0, data: 32'h0403_0201});
    seq = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_bytes(seq);
    reset   = 1'b1;
    load_en = 1'b0;
    tick(2);
    check_reset_outputs("mid_reset");
    check("mid_reset_pending", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    tick(2);
    arm();
    send_image1(8'h90);
    check_status("reload", 1'b1, 1'b0, 1'b0, 1'b0);

    // Dropping load_en mid-data aborts the load
    arm();
    seq = '{8'h01, 8'h00, 8'hAA};
    send_bytes(seq);
    load_en = 1'b0;
    tick(2);
    check_status("load_drop", 1'b0, 1'b1, 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum: words still written, load fails
    arm();
    send_image1(8'h00);
    check_status("bad_csum", 1'b0, 1'b1, 1'b1, 1'b0);
`endif

    tick(4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
